// File: rtl/mux_n_1_arb_pkg.sv
// Shared definitions for the N:1 arbitrated multiplexer: mode encodings
// and the helper that sizes channel index fields.
package mux_pkg;

    // Encoding of the mode_rr input.
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Width of a channel index for n channels: ceil(log2(n)), at least 1.
    function automatic int calc_ch_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_n_1_arb_rr_arbiter.sv
// Round-robin priority search: grants the lowest requesting channel at or
// above ptr, otherwise wraps and grants the lowest requesting channel overall.
// Purely combinational; the pointer register is owned by the caller.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = calc_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    logic [NUM_CH-1:0] w_req_hi;

    // Requests at or above the pointer take priority over wrapped ones.
    always_comb begin
        // NOTE: every signal driven here gets a default before any condition,
        // otherwise a missed branch would infer a latch.
        w_req_hi = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_req_hi[k] = req[k] && (k >= int'(ptr));
        end
    end

    // Lowest set bit of req, then overridden by the lowest set bit of the
    // upper (non-wrapped) region when that region has any request.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant_idx   = CH_W'(k);
                grant_valid = 1'b1;
            end
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_req_hi[k]) begin
                grant_idx = CH_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_arb.sv
// N:1 multiplexer with selector or round-robin arbitration and a single
// registered output stage (valid/ready on both sides, 1-cycle latency,
// full throughput). The only path to ready_out is from the control inputs;
// data_in reaches the outputs only through registers.
module mux_n_1_arb
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 2,
    localparam int CH_W   = calc_ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode_rr,
    input  logic [CH_W-1:0]          selector,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        valid_in,
    output logic [NUM_CH-1:0]        ready_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [CH_W-1:0]          ch_out,
    output logic                     valid_out,
    input  logic                     ready_in
);

    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_ch;
    logic              r_valid;
    logic [CH_W-1:0]   r_rr_ptr;

    logic              w_load;
    logic [CH_W-1:0]   w_rr_grant;
    logic              w_rr_valid;
    logic              w_sel_valid;
    logic [CH_W-1:0]   w_grant;
    logic              w_grant_valid;
    logic              w_xfer;
    logic [DATA_W-1:0] w_grant_data;
    logic [CH_W-1:0]   w_ptr_next;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req         (valid_in),
        .ptr         (r_rr_ptr),
        .grant_idx   (w_rr_grant),
        .grant_valid (w_rr_valid)
    );

    // The output register may take a new word when empty or being drained.
    assign w_load = !r_valid || ready_in;

    // Selector mode: an out-of-range selector matches no channel, so no grant.
    always_comb begin
        w_sel_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == selector) begin
                w_sel_valid = valid_in[k];
            end
        end
    end

    // Pick the active arbitration result for this cycle.
    always_comb begin
        if (mode_rr == MODE_RR) begin
            w_grant       = w_rr_grant;
            w_grant_valid = w_rr_valid;
        end else begin
            w_grant       = selector;
            w_grant_valid = w_sel_valid;
        end
    end

    // Reset holds off any handshake so no word is accepted and then lost.
    assign w_xfer = w_grant_valid && w_load && !reset;

    // One-hot ready to the granted channel; data mux of the granted channel.
    always_comb begin
        ready_out    = '0;
        w_grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == w_grant) begin
                ready_out[k] = w_xfer;
                w_grant_data = data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves to the channel after the one just served, wrapping.
    assign w_ptr_next = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_data   <= '0;
            r_ch     <= '0;
            r_valid  <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            if (w_xfer) begin
                r_data  <= w_grant_data;
                r_ch    <= w_grant;
                r_valid <= 1'b1;
                if (mode_rr == MODE_RR) begin
                    r_rr_ptr <= w_ptr_next;
                end
            end else if (ready_in) begin
                // Word drained with nothing to replace it; data and index hold.
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign ch_out    = r_ch;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_mux_n_1_arb.sv
// Directed bench for mux_n_1_arb. The 4-channel instance is scoreboarded:
// stimulus pushes each expected output word, a monitor pops and compares it
// whenever the DUT hands a word downstream. A 3-channel instance covers the
// out-of-range selector case with direct checks.
module tb_mux_n_1_arb;

    typedef struct packed {
        logic [1:0] data;
        logic [1:0] ch;
    } exp_t;

    logic       clk;
    logic       reset;

    // 4-channel DUT
    logic       mode_rr4;
    logic [1:0] selector4;
    logic [7:0] data_in4;
    logic [3:0] valid_in4;
    logic [3:0] ready_out4;
    logic [1:0] data_out4;
    logic [1:0] ch_out4;
    logic       valid_out4;
    logic       ready_in4;

    // 3-channel DUT
    logic       mode_rr3;
    logic [1:0] selector3;
    logic [5:0] data_in3;
    logic [2:0] valid_in3;
    logic [2:0] ready_out3;
    logic [1:0] data_out3;
    logic [1:0] ch_out3;
    logic       valid_out3;
    logic       ready_in3;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Channel data pattern used by most tests: ch0=00 ch1=01 ch2=11 ch3=10.
    localparam logic [7:0] PAT_A = 8'b10_11_01_00;

    mux_n_1_arb #(.NUM_CH(4), .DATA_W(2)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .mode_rr   (mode_rr4),
        .selector  (selector4),
        .data_in   (data_in4),
        .valid_in  (valid_in4),
        .ready_out (ready_out4),
        .data_out  (data_out4),
        .ch_out    (ch_out4),
        .valid_out (valid_out4),
        .ready_in  (ready_in4)
    );

    mux_n_1_arb #(.NUM_CH(3), .DATA_W(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .mode_rr   (mode_rr3),
        .selector  (selector3),
        .data_in   (data_in3),
        .valid_in  (valid_in3),
        .ready_out (ready_out3),
        .data_out  (data_out3),
        .ch_out    (ch_out3),
        .valid_out (valid_out3),
        .ready_in  (ready_in3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_vec++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] d, input logic [1:0] c);
        exp_t e;
        e.data = d;
        e.ch   = c;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every word the 4-channel DUT hands downstream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && valid_out4 && ready_in4) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data=%0h ch=%0d, required no word",
                             data_out4, ch_out4);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_word", {data_out4, ch_out4}, {e.data, e.ch});
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rr_seq [6];
        logic [3:0] rr_rdy [6];
        logic [1:0] pat_d  [4];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        pat_d  = '{2'b00, 2'b01, 2'b11, 2'b10};

        reset     = 1'b1;
        mode_rr4  = 1'b0;
        selector4 = 2'd0;
        data_in4  = PAT_A;
        valid_in4 = 4'b1111;
        ready_in4 = 1'b1;
        mode_rr3  = 1'b0;
        selector3 = 2'd0;
        data_in3  = 6'b10_01_11;
        valid_in3 = 3'b000;
        ready_in3 = 1'b0;

        // Reset state, with requests pending: nothing granted, outputs clear.
        #2;
        check("reset_outputs", {data_out4, ch_out4, valid_out4}, 5'b0);
        check("reset_ready", ready_out4, 4'b0000);
        tick();
        tick();
        check("reset_hold_outputs", {data_out4, ch_out4, valid_out4}, 5'b0);
        check("reset_hold_ready", ready_out4, 4'b0000);
        reset = 1'b0;

        // Selector mode, selector=2, all valid.
        mode_rr4  = 1'b0;
        selector4 = 2'd2;
        valid_in4 = 4'b1111;
        #1;
        check("sel_ready", ready_out4, 4'b0100);
        push_exp(2'b11, 2'd2);
        tick();
        valid_in4 = 4'b0000;
        #1;
        check("sel_out", {data_out4, ch_out4, valid_out4}, {2'b11, 2'd2, 1'b1});
        check("idle_ready", ready_out4, 4'b0000);
        tick();
        check("drain_valid_drop", valid_out4, 1'b0);
        check("drain_hold", {data_out4, ch_out4}, {2'b11, 2'd2});

        // Round-robin with all channels requesting: 0,1,2,3,0,1.
        mode_rr4  = 1'b1;
        valid_in4 = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_ready", ready_out4, rr_rdy[i]);
            push_exp(pat_d[rr_seq[i]], rr_seq[i]);
            if (i > 0) begin
                check("rr_stream", {ch_out4, valid_out4}, {rr_seq[i-1], 1'b1});
            end
            tick();
        end
        valid_in4 = 4'b0000;
        #1;
        check("rr_last", {ch_out4, valid_out4}, {2'd1, 1'b1});
        tick();

        // Sparse requests: pointer at 2 -> ch2, then wrap from 3 to ch0, then ch2.
        valid_in4 = 4'b0100;
        #1;
        check("sparse_ready_a", ready_out4, 4'b0100);
        push_exp(2'b11, 2'd2);
        tick();
        valid_in4 = 4'b0101;
        #1;
        check("wrap_ready", ready_out4, 4'b0001);
        push_exp(2'b00, 2'd0);
        tick();
        #1;
        check("post_wrap_ready", ready_out4, 4'b0100);
        push_exp(2'b11, 2'd2);
        tick();
        valid_in4 = 4'b0000;
        tick();

        // Backpressure: load ch3, stall 3 cycles while inputs change, release.
        valid_in4 = 4'b1111;
        #1;
        check("bp_load_ready", ready_out4, 4'b1000);
        push_exp(2'b10, 2'd3);
        tick();
        ready_in4 = 1'b0;
        data_in4  = 8'b01_01_01_01;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", ready_out4, 4'b0000);
            check("bp_hold", {data_out4, ch_out4, valid_out4}, {2'b10, 2'd3, 1'b1});
            tick();
        end
        check("bp_hold_end", {data_out4, ch_out4, valid_out4}, {2'b10, 2'd3, 1'b1});
        ready_in4 = 1'b1;
        #1;
        check("bp_release_ready", ready_out4, 4'b0001);
        push_exp(2'b01, 2'd0);
        tick();
        check("bp_same_edge_load", {data_out4, ch_out4, valid_out4}, {2'b01, 2'd0, 1'b1});
        valid_in4 = 4'b0000;
        tick();

        // Reset mid-stream: held word discarded, outputs clear without a clock edge.
        valid_in4 = 4'b0010;
        #1;
        check("pre_reset_ready", ready_out4, 4'b0010);
        tick();
        ready_in4 = 1'b0;
        valid_in4 = 4'b1111;
        #1;
        check("pre_reset_held", valid_out4, 1'b1);
        #1;
        reset     = 1'b1;
        ready_in4 = 1'b1;
        #1;
        check("async_reset_outputs", {data_out4, ch_out4, valid_out4}, 5'b0);
        check("async_reset_ready", ready_out4, 4'b0000);
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_ptr_ready", ready_out4, 4'b0001);
        push_exp(2'b01, 2'd0);
        tick();
        valid_in4 = 4'b0000;
        tick();

        // 3-channel instance: load ch1, then out-of-range selector grants nothing.
        selector3 = 2'd1;
        valid_in3 = 3'b111;
        ready_in3 = 1'b0;
        #1;
        check("sel3_ready", ready_out3, 3'b010);
        tick();
        check("sel3_out", {data_out3, ch_out3, valid_out3}, {2'b01, 2'd1, 1'b1});
        selector3 = 2'd3;
        #1;
        check("sel3_oor_stall_ready", ready_out3, 3'b000);
        tick();
        check("sel3_oor_stall_hold", valid_out3, 1'b1);
        ready_in3 = 1'b1;
        #1;
        check("sel3_oor_ready", ready_out3, 3'b000);
        tick();
        check("sel3_oor_drop", valid_out3, 1'b0);
        check("sel3_oor_ready_after", ready_out3, 3'b000);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
